// File: rtl/div_sequencer.sv
// div_sequencer: operand front-end and result back-end for the 8-bit
// non-restoring divider core. Screens divide-by-zero, optionally folds signed
// operands to magnitudes, runs the core and deserialises its quotient and
// remainder bytes into a held result with a valid/ready handshake.
module div_sequencer #(
   parameter bit SIGNED  = 1'b0,
   parameter int TIMEOUT = 31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_dividend,
   input  logic [7:0] in_divisor,
   output logic       div_reset,
   output logic       div_start,
   output logic [7:0] div_Q,
   output logic [7:0] div_M,
   input  logic       div_busy,
   input  logic [7:0] div_outbus,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_quot,
   output logic [7:0] out_rem,
   output logic       out_dz,
   output logic       out_timeout
);

   typedef enum logic [2:0] {IDLE, LOAD, START, RUN, FIX, OUT} state_t;

   state_t     state, state_nxt;
   logic       accept;
   logic       zero_div;
   logic       tmo;
   logic       run_done;
   logic [4:0] cnt;
   logic [5:0] cnt_inc;
   logic [7:0] last_byte;
   logic [7:0] quot_raw, rem_raw;
   logic       neg_q, neg_r;
   logic [7:0] mag_q, mag_m;

   assign zero_div = (in_divisor == 8'h00);
   assign cnt_inc  = {1'b0, cnt} + 6'd1;
   // Abort on the cycle whose increment makes the counter reach TIMEOUT, so
   // at most TIMEOUT cycles are spent waiting on the core.
   assign tmo      = ((state == START) || (state == RUN)) && (cnt_inc == 6'(TIMEOUT));
   assign run_done = (state == RUN) && !div_busy && !tmo;

   // The core is reset by the system reset and by the one-cycle LOAD pulse.
   assign div_reset = reset | (state == LOAD);

   // Magnitude conversion; -128 folds to 8'h80 which the core reads as 128.
   assign mag_q = (SIGNED && in_dividend[7]) ? 8'(-in_dividend) : in_dividend;
   assign mag_m = (SIGNED && in_divisor[7])  ? 8'(-in_divisor)  : in_divisor;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and handshake/core-control outputs.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      div_start = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept    = 1'b1;
               state_nxt = zero_div ? OUT : LOAD;
            end
         end
         LOAD:  state_nxt = START;
         START: begin
            div_start = 1'b1;
            if (tmo)           state_nxt = OUT;
            else if (div_busy) state_nxt = RUN;
         end
         RUN: begin
            if (tmo)            state_nxt = OUT;
            else if (!div_busy) state_nxt = FIX;
         end
         FIX:   state_nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture: magnitudes to the core plus the result sign flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_Q <= 8'h00;
         div_M <= 8'h00;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (accept && !zero_div) begin
         div_Q <= mag_q;
         div_M <= mag_m;
         neg_q <= SIGNED ? (in_dividend[7] ^ in_divisor[7]) : 1'b0;
         neg_r <= SIGNED ? in_dividend[7] : 1'b0;
      end
   end

   // Timeout counter (cleared while in LOAD, i.e. on entry to START) and the
   // result-byte deserialiser: the byte seen on the last busy cycle is the
   // quotient, the byte on the first idle cycle is the remainder.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= 5'd0;
         last_byte <= 8'h00;
         quot_raw  <= 8'h00;
         rem_raw   <= 8'h00;
      end else begin
         if (state == LOAD)                        cnt <= 5'd0;
         else if ((state == START) || (state == RUN)) cnt <= cnt_inc[4:0];
         if (state == RUN) last_byte <= div_outbus;
         if (run_done) begin
            quot_raw <= last_byte;
            rem_raw  <= div_outbus;
         end
      end
   end

   // Result register: written only on the transition into OUT, held after.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_quot    <= 8'h00;
         out_rem     <= 8'h00;
         out_dz      <= 1'b0;
         out_timeout <= 1'b0;
      end else if (accept && zero_div) begin
         out_quot    <= 8'hFF;
         out_rem     <= in_dividend;
         out_dz      <= 1'b1;
         out_timeout <= 1'b0;
      end else if (tmo) begin
         out_quot    <= 8'h00;
         out_rem     <= 8'h00;
         out_dz      <= 1'b0;
         out_timeout <= 1'b1;
      end else if (state == FIX) begin
         out_quot    <= neg_q ? 8'(-quot_raw) : quot_raw;
         out_rem     <= neg_r ? 8'(-rem_raw)  : rem_raw;
         out_dz      <= 1'b0;
         out_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: an unsigned and a signed instance, each driving a
// behavioural divider core (or a stuck-busy stub), checked against plain
// integer division.
module tb_div_sequencer;
   localparam int TMO = 31;
   localparam int NB  = 10;   // core busy cycles: 8 iterations + 2 output

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid    [2];
   logic [7:0] in_dividend [2];
   logic [7:0] in_divisor  [2];
   logic       out_ready   [2];
   logic       stub        [2];
   logic       in_ready    [2];
   logic       div_reset   [2];
   logic       div_start   [2];
   logic [7:0] div_Q       [2];
   logic [7:0] div_M       [2];
   logic       out_valid   [2];
   logic [7:0] out_quot    [2];
   logic [7:0] out_rem     [2];
   logic       out_dz      [2];
   logic       out_timeout [2];
   int         ncmp = 0;
   int         nerr = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic       busy;
      logic [7:0] bus;
      logic       run;
      int         t, d;
      logic [7:0] cq, cr;

      div_sequencer #(.SIGNED(g == 1), .TIMEOUT(TMO)) u_dut (
         .clk         (clk),
         .reset       (reset),
         .in_valid    (in_valid[g]),
         .in_ready    (in_ready[g]),
         .in_dividend (in_dividend[g]),
         .in_divisor  (in_divisor[g]),
         .div_reset   (div_reset[g]),
         .div_start   (div_start[g]),
         .div_Q       (div_Q[g]),
         .div_M       (div_M[g]),
         .div_busy    (busy),
         .div_outbus  (bus),
         .out_valid   (out_valid[g]),
         .out_ready   (out_ready[g]),
         .out_quot    (out_quot[g]),
         .out_rem     (out_rem[g]),
         .out_dz      (out_dz[g]),
         .out_timeout (out_timeout[g])
      );

      // Core model: busy 1-2 cycles after start, busy for NB cycles, quotient
      // on the bus in the last busy cycle, remainder in the first idle one.
      always @(posedge clk) begin
         if (div_reset[g]) begin
            run <= 1'b0; t <= 0; busy <= 1'b0; bus <= 8'h00;
         end else if (stub[g]) begin
            if (div_start[g]) busy <= 1'b1;
         end else if (!run) begin
            busy <= 1'b0;
            if (div_start[g]) begin
               run <= 1'b1;
               t   <= 1;
               d   <= int'($urandom_range(2, 1));
               cq  <= div_Q[g] / div_M[g];
               cr  <= div_Q[g] % div_M[g];
            end
         end else begin
            t    <= t + 1;
            busy <= (t >= d) && (t < d + NB);
            bus  <= (t == d + NB - 1) ? cq : (t == d + NB) ? cr : 8'($urandom);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the arithmetic result truncated to 8 bits.
   function automatic void model(input int k, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] r, output logic dz);
      int x, y;
      x = k ? int'($signed(a)) : int'(a);
      y = k ? int'($signed(b)) : int'(b);
      if (y == 0) begin q = 8'hFF; r = a; dz = 1'b1; end
      else begin q = 8'(x / y); r = 8'(x % y); dz = 1'b0; end
   endfunction

   function automatic logic [7:0] mag(input int k, input logic [7:0] a);
      int v;
      v = k ? int'($signed(a)) : int'(a);
      return 8'(v < 0 ? -v : v);
   endfunction

   // One operation on instance k; hold = extra cycles of out_ready low.
   task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input int hold, input bit exp_to);
      logic [7:0] eq, er;
      logic       edz;
      int         lat;
      bit         seen_start;
      if (exp_to) begin eq = 8'h00; er = 8'h00; edz = 1'b0; end
      else model(k, a, b, eq, er, edz);
      @(negedge clk);
      chk("in_ready_idle", in_ready[k], 1);
      in_valid[k] = 1'b1; in_dividend[k] = a; in_divisor[k] = b;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      in_dividend[k] = 8'($urandom); in_divisor[k] = 8'($urandom);
      if (b != 8'h00) begin
         chk("div_Q", div_Q[k], mag(k, a));
         chk("div_M", div_M[k], mag(k, b));
      end
      lat = 0; seen_start = 0;
      while (!out_valid[k] && lat < 40) begin
         if (div_start[k]) seen_start = 1;
         @(posedge clk); #1;
         lat++;
      end
      chk("out_valid_arrive", out_valid[k], 1);
      if (b == 8'h00) begin
         chk("dz_latency", lat, 0);
         chk("dz_no_start", seen_start, 0);
      end else if (exp_to) chk("to_latency", (lat >= TMO - 1) && (lat <= TMO + 3), 1);
      else chk("latency_le16", lat <= 16, 1);
      for (int i = 0; i <= hold; i++) begin
         chk("quot", out_quot[k], eq);
         chk("rem", out_rem[k], er);
         chk("dz", out_dz[k], edz);
         chk("timeout", out_timeout[k], exp_to);
         chk("valid_hold", out_valid[k], 1);
         chk("in_ready_busy", in_ready[k], 0);
         if (i == hold) out_ready[k] = 1'b1;
         @(posedge clk); #1;
      end
      out_ready[k] = 1'b0;
      chk("valid_drop", out_valid[k], 0);
      chk("in_ready_back", in_ready[k], 1);
   endtask

   initial begin
      bit seen;
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0; in_dividend[k] = 8'h00; in_divisor[k] = 8'h00;
         out_ready[k] = 1'b0; stub[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_ready", in_ready[k], 1);
         chk("rst_out_valid", out_valid[k], 0);
         chk("rst_div_start", div_start[k], 0);
         chk("rst_div_reset", div_reset[k], 1);
         chk("rst_quot", out_quot[k], 0);
         chk("rst_rem", out_rem[k], 0);
         chk("rst_div_Q", div_Q[k], 0);
         chk("rst_div_M", div_M[k], 0);
         chk("rst_dz", out_dz[k], 0);
         chk("rst_timeout", out_timeout[k], 0);
      end
      @(negedge clk); reset = 1'b0;

      // Directed cases.
      do_op(0, 8'd100, 8'd7, 0, 0);
      do_op(0, 8'd55, 8'd0, 0, 0);
      do_op(1, 8'(-100), 8'd7, 0, 0);
      do_op(1, 8'd100, 8'(-7), 0, 0);
      do_op(1, 8'h80, 8'd1, 0, 0);
      do_op(1, 8'h80, 8'hFF, 1, 0);
      do_op(1, 8'(-55), 8'd0, 2, 0);
      do_op(0, 8'd200, 8'd9, 5, 0);
      do_op(0, 8'd13, 8'd4, 0, 0);
      do_op(0, 8'd255, 8'd1, 0, 0);

      // Stuck core, then recovery on a working core.
      stub[0] = 1'b1; do_op(0, 8'd77, 8'd3, 1, 1);
      stub[0] = 1'b0; do_op(0, 8'd77, 8'd3, 0, 0);
      stub[1] = 1'b1; do_op(1, 8'(-77), 8'd3, 0, 1);
      stub[1] = 1'b0; do_op(1, 8'(-77), 8'd3, 0, 0);

      // Random operations on both flavours.
      for (int i = 0; i < 40; i++) begin
         int         k;
         logic [7:0] a, b;
         k = int'($urandom_range(1, 0));
         a = 8'($urandom);
         b = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom);
         do_op(k, a, b, int'($urandom_range(3, 0)), 0);
      end

      // Reset in the middle of RUN discards the operation.
      @(negedge clk);
      in_valid[0] = 1'b1; in_dividend[0] = 8'd100; in_divisor[0] = 8'd7;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (6) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid[0], 0);
      chk("midrst_in_ready", in_ready[0], 1);
      chk("midrst_div_reset", div_reset[0], 1);
      chk("midrst_div_start", div_start[0], 0);
      chk("midrst_div_Q", div_Q[0], 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid[0]) seen = 1;
      end
      chk("midrst_no_stale", seen, 0);
      do_op(0, 8'd200, 8'd9, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
